// File: rtl/uart_spi_cmd_bridge.sv
// rtl/uart_spi_cmd_bridge.sv - framed UART command decoder driving one SPI transfer per frame
// Purpose: parses HEADER,ADDR,DATA,CSUM frames from uart_rx. A good frame runs one
//   SPI transfer (upper=ADDR, lower=DATA). Every complete frame is answered over
//   uart_tx with a status byte followed by a data byte.
// Optional feature: define UART_CMD_TIMEOUT_EN to build the inter-byte and
//   SPI-wait timeout counter (TIMEOUT_CLKS clocks).
// Ports:
//   i_clock, i_reset_n                       clock, synchronous active-low reset
//   i_rx_dv, i_rx_byte                       received byte strobe and value
//   o_spi_start, o_spi_upper, o_spi_lower    SPI transfer request and Tx bytes
//   i_spi_busy, i_spi_done, i_spi_rx_byte    SPI status and read-back byte
//   o_tx_dv, o_tx_byte                       uart_tx byte request and byte
//   i_tx_active, i_tx_done                   uart_tx status
//   o_frame_err                              pulse on checksum error or timeout
//   o_busy                                   high whenever the bridge is not idle
module uart_spi_cmd_bridge #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter logic [7:0] ACK          = 8'h06,
  parameter logic [7:0] NAK          = 8'h15,
  parameter int         TIMEOUT_CLKS = 17360
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_spi_start,
  output logic [7:0] o_spi_upper,
  output logic [7:0] o_spi_lower,
  input  logic       i_spi_busy,
  input  logic       i_spi_done,
  input  logic [7:0] i_spi_rx_byte,
  output logic       o_tx_dv,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_active,
  input  logic       i_tx_done,
  output logic       o_frame_err,
  output logic       o_busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_GET_CSUM, S_SPI_START,
    S_SPI_WAIT, S_TX_STAT, S_TX_STAT_W, S_TX_DATA, S_TX_DATA_W
  } state_e;

  state_e     state_q;
  logic [7:0] status_q;
  logic [7:0] reply_q;
  logic       spi_start_q;
  logic [7:0] spi_upper_q;
  logic [7:0] spi_lower_q;
  logic       tx_dv_q;
  logic [7:0] tx_byte_q;
  logic       frame_err_q;
  logic       timeout_hit;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);

  logic [TW-1:0] tmr_q;
  logic          in_get;
  logic          timed;

  assign in_get = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA) || (state_q == S_GET_CSUM);
  assign timed  = in_get || (state_q == S_SPI_WAIT);
  // Fires on the TIMEOUT_CLKS-th silent clock; the FSM checks the byte/done first,
  // so a byte arriving in the expiry cycle still wins.
  assign timeout_hit = timed && (tmr_q == TW'(TIMEOUT_CLKS - 1));

  // Cleared outside the timed states so each GET_*/SPI_WAIT stay starts from zero.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n || !timed || (in_get && i_rx_dv)) begin
      tmr_q <= '0;
    end else if (tmr_q != TW'(TIMEOUT_CLKS - 1)) begin
      tmr_q <= tmr_q + 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout_clks;

  assign unused_timeout_clks = TIMEOUT_CLKS;
  assign timeout_hit         = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      status_q    <= '0;
      reply_q     <= '0;
      spi_start_q <= 1'b0;
      spi_upper_q <= '0;
      spi_lower_q <= '0;
      tx_dv_q     <= 1'b0;
      tx_byte_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      spi_start_q <= 1'b0;
      tx_dv_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_rx_dv && (i_rx_byte == HEADER)) state_q <= S_GET_ADDR;
        end
        S_GET_ADDR: begin
          if (i_rx_dv) begin
            spi_upper_q <= i_rx_byte;
            state_q     <= S_GET_DATA;
          end else if (timeout_hit) begin
            frame_err_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_GET_DATA: begin
          if (i_rx_dv) begin
            spi_lower_q <= i_rx_byte;
            state_q     <= S_GET_CSUM;
          end else if (timeout_hit) begin
            frame_err_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_GET_CSUM: begin
          if (i_rx_dv) begin
            if ((HEADER ^ spi_upper_q ^ spi_lower_q) == i_rx_byte) begin
              state_q <= S_SPI_START;
            end else begin
              frame_err_q <= 1'b1;
              status_q    <= NAK;
              reply_q     <= '0;
              state_q     <= S_TX_STAT;
            end
          end else if (timeout_hit) begin
            frame_err_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_SPI_START: begin
          if (!i_spi_busy) begin
            spi_start_q <= 1'b1;
            state_q     <= S_SPI_WAIT;
          end
        end
        S_SPI_WAIT: begin
          if (i_spi_done) begin
            status_q <= ACK;
            reply_q  <= i_spi_rx_byte;
            // Launch the status byte directly when uart_tx is free so the reply
            // starts one clock after spi done instead of two.
            if (!i_tx_active) begin
              tx_byte_q <= ACK;
              tx_dv_q   <= 1'b1;
              state_q   <= S_TX_STAT_W;
            end else begin
              state_q <= S_TX_STAT;
            end
          end else if (timeout_hit) begin
            frame_err_q <= 1'b1;
            status_q    <= NAK;
            reply_q     <= '0;
            state_q     <= S_TX_STAT;
          end
        end
        S_TX_STAT: begin
          if (!i_tx_active) begin
            tx_byte_q <= status_q;
            tx_dv_q   <= 1'b1;
            state_q   <= S_TX_STAT_W;
          end
        end
        S_TX_STAT_W: begin
          if (i_tx_done) state_q <= S_TX_DATA;
        end
        S_TX_DATA: begin
          if (!i_tx_active) begin
            tx_byte_q <= reply_q;
            tx_dv_q   <= 1'b1;
            state_q   <= S_TX_DATA_W;
          end
        end
        S_TX_DATA_W: begin
          if (i_tx_done) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_spi_start = spi_start_q;
  assign o_spi_upper = spi_upper_q;
  assign o_spi_lower = spi_lower_q;
  assign o_tx_dv     = tx_dv_q;
  assign o_tx_byte   = tx_byte_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_spi_cmd_bridge.sv
// tb/tb_uart_spi_cmd_bridge.sv - self-checking bench for uart_spi_cmd_bridge
module tb_uart_spi_cmd_bridge;

  localparam logic [7:0] HDR  = 8'hA5;
  localparam logic [7:0] ACKB = 8'h06;
  localparam logic [7:0] NAKB = 8'h15;
  localparam int         TMO  = 17360;

  typedef struct {
    logic [5:0][7:0] b;
    int              n;
    logic [7:0]      spi_rx;
    int              exp_spi;
    logic [7:0]      exp_up;
    logic [7:0]      exp_lo;
    int              exp_ntx;
    logic [7:0]      exp_t0;
    logic [7:0]      exp_t1;
    int              exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       spi_start;
  logic [7:0] spi_upper, spi_lower;
  logic       spi_busy = 1'b0;
  logic       spi_done = 1'b0;
  logic [7:0] spi_resp = 8'h00;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_active;
  logic       tx_done = 1'b0;
  logic       frame_err;
  logic       busy;

  logic       tx_act_m = 1'b0;
  logic       tx_force = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_spi = 0, n_err = 0, spi_cnt = 0, tx_cnt = 0;
  int spi_lat = 2, tx_lat = 3;
  int start_cyc = 0, done_cyc = 0, last_rx_cyc = 0;
  logic [7:0] cap_up = 8'h00, cap_lo = 8'h00, tx_hold = 8'h00;
  logic [7:0] tx_q[$];
  int         txc[$];

  assign tx_active = tx_act_m | tx_force;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  uart_spi_cmd_bridge dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
    .o_spi_start(spi_start), .o_spi_upper(spi_upper), .o_spi_lower(spi_lower),
    .i_spi_busy(spi_busy), .i_spi_done(spi_done), .i_spi_rx_byte(spi_resp),
    .o_tx_dv(tx_dv), .o_tx_byte(tx_byte), .i_tx_active(tx_active), .i_tx_done(tx_done),
    .o_frame_err(frame_err), .o_busy(busy)
  );

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %02h required %02h", name, act, req);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0b required %0b", name, act, req);
    end
  endtask

  task automatic chki(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // SPI master stand-in: busy for spi_lat cycles after a start, then a done pulse.
  always @(negedge clk) begin
    spi_done = 1'b0;
    if (!rst_n) begin
      spi_busy = 1'b0;
      spi_cnt  = 0;
    end else begin
      if (spi_busy) begin
        if (spi_cnt == 0) begin
          spi_busy = 1'b0;
          spi_done = 1'b1;
          done_cyc = cyc;
        end else begin
          spi_cnt--;
        end
      end
      if (spi_start) begin
        n_spi++;
        cap_up    = spi_upper;
        cap_lo    = spi_lower;
        start_cyc = cyc;
        spi_busy  = 1'b1;
        spi_cnt   = spi_lat;
      end
      if (frame_err) n_err++;
    end
  end

  // uart_tx stand-in: records every byte, stays active tx_lat cycles, then done.
  always @(negedge clk) begin
    logic was_act;
    was_act = tx_act_m;
    tx_done = 1'b0;
    if (!rst_n) begin
      tx_act_m = 1'b0;
      tx_cnt   = 0;
    end else begin
      if (tx_act_m) begin
        if (tx_cnt == 0) begin
          chk8("tx_byte_held", tx_byte, tx_hold);
          tx_act_m = 1'b0;
          tx_done  = 1'b1;
        end else begin
          tx_cnt--;
        end
      end
      if (tx_dv) begin
        if (was_act) begin
          failures++;
          $display("FAIL tx_dv_while_active: got 1 required 0");
        end
        tx_q.push_back(tx_byte);
        txc.push_back(cyc);
        tx_hold  = tx_byte;
        tx_act_m = 1'b1;
        tx_cnt   = tx_lat;
      end
    end
  end

  function automatic vec_t mkv(input logic [7:0] b0, b1, b2, b3, b4, b5, input int n,
                               input logic [7:0] resp, input int es, input logic [7:0] eu, el,
                               input int ntx, input logic [7:0] t0, t1, input int ee);
    vec_t v;
    v.b = {b5, b4, b3, b2, b1, b0};
    v.n = n; v.spi_rx = resp; v.exp_spi = es; v.exp_up = eu; v.exp_lo = el;
    v.exp_ntx = ntx; v.exp_t0 = t0; v.exp_t1 = t1; v.exp_err = ee;
    return v;
  endfunction

  // Reference: skip bytes until HEADER, take the next three as ADDR, DATA, CSUM.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    logic [7:0] f[3];
    int got;
    r = v;
    r.exp_spi = 0; r.exp_up = 8'h00; r.exp_lo = 8'h00;
    r.exp_ntx = 0; r.exp_t0 = 8'h00; r.exp_t1 = 8'h00; r.exp_err = 0;
    got = -1;
    for (int i = 0; i < v.n; i++) begin
      if (got < 0) begin
        if (v.b[i] == HDR) got = 0;
      end else if (got < 3) begin
        f[got] = v.b[i];
        got++;
      end
    end
    if (got == 3) begin
      r.exp_ntx = 2;
      if ((HDR ^ f[0] ^ f[1]) == f[2]) begin
        r.exp_spi = 1; r.exp_up = f[0]; r.exp_lo = f[1];
        r.exp_t0 = ACKB; r.exp_t1 = v.spi_rx;
      end else begin
        r.exp_err = 1; r.exp_t0 = NAKB; r.exp_t1 = 8'h00;
      end
    end
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_dv = 1'b1;
    last_rx_cyc = cyc;
    @(negedge clk);
    rx_dv = 1'b0;
    repeat ($urandom_range(2, 6)) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk1({tag, "_idle_in_time"}, busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int b_spi, b_err, b_tx;
    b_spi = n_spi; b_err = n_err; b_tx = tx_q.size();
    spi_resp = v.spi_rx;
    spi_lat = $urandom_range(0, 5);
    tx_lat = $urandom_range(1, 6);
    for (int i = 0; i < v.n; i++) send_byte(v.b[i]);
    wait_idle(tag);
    chki({tag, "_spi_count"}, n_spi - b_spi, v.exp_spi);
    if (v.exp_spi > 0) begin
      chk8({tag, "_spi_upper"}, cap_up, v.exp_up);
      chk8({tag, "_spi_lower"}, cap_lo, v.exp_lo);
    end
    chki({tag, "_tx_count"}, tx_q.size() - b_tx, v.exp_ntx);
    if (v.exp_ntx == 2 && tx_q.size() >= b_tx + 2) begin
      chk8({tag, "_tx_status"}, tx_q[b_tx], v.exp_t0);
      chk8({tag, "_tx_data"}, tx_q[b_tx+1], v.exp_t1);
    end
    chki({tag, "_frame_err_count"}, n_err - b_err, v.exp_err);
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_spi_start"}, spi_start, 1'b0);
    chk8({tag, "_spi_upper"}, spi_upper, 8'h00);
    chk8({tag, "_spi_lower"}, spi_lower, 8'h00);
    chk1({tag, "_tx_dv"}, tx_dv, 1'b0);
    chk8({tag, "_tx_byte"}, tx_byte, 8'h00);
    chk1({tag, "_frame_err"}, frame_err, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    vec_t v;
    logic [7:0] a, d, c, jb;
    int nj, k, b_spi, b_err, b_tx;

    vt.push_back(mkv(8'hA5, 8'hF8, 8'h00, 8'h5D, 8'h00, 8'h00, 4, 8'h3C, 1, 8'hF8, 8'h00, 2, ACKB, 8'h3C, 0));
    vt.push_back(mkv(8'hA5, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h00, 4, 8'h99, 0, 8'h00, 8'h00, 2, NAKB, 8'h00, 1));
    vt.push_back(mkv(8'h11, 8'h22, 8'hA5, 8'h01, 8'h02, 8'hA6, 6, 8'h5A, 1, 8'h01, 8'h02, 2, ACKB, 8'h5A, 0));
    vt.push_back(mkv(8'hA5, 8'hFF, 8'hFF, 8'hA5, 8'h00, 8'h00, 4, 8'h00, 1, 8'hFF, 8'hFF, 2, ACKB, 8'h00, 0));
    vt.push_back(mkv(8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 2, 8'h12, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00, 0));
    vt.push_back(mkv(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00, 4, 8'hE7, 1, 8'hA5, 8'hA5, 2, ACKB, 8'hE7, 0));
    for (int r = 0; r < 10; r++) begin
      v.b = '0;
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        jb = 8'($urandom_range(0, 255));
        if (jb == HDR) jb = 8'h00;
        v.b[j] = jb;
      end
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      c = HDR ^ a ^ d;
      if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
      v.b[nj] = HDR; v.b[nj+1] = a; v.b[nj+2] = d; v.b[nj+3] = c;
      v.n = nj + 4;
      v.spi_rx = 8'($urandom_range(0, 255));
      vt.push_back(ref_model(v));
    end

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      b_tx = tx_q.size();
      run_vec(vt[i], $sformatf("v%0d", i));
      if (i == 0) begin
        chki("lat_rx_to_spi_start", start_cyc - last_rx_cyc, 2);
        if (txc.size() > b_tx) chki("lat_spi_done_to_tx_dv", txc[b_tx] - done_cyc, 1);
      end
    end

    // Reset while the SPI transfer is outstanding.
    spi_lat = 40;
    b_spi = n_spi;
    b_tx = tx_q.size();
    send_byte(8'hA5); send_byte(8'hF8); send_byte(8'h00); send_byte(8'h5D);
    k = 0;
    while (n_spi == b_spi && k < 50) begin
      @(negedge clk);
      k++;
    end
    chki("rst_mid_spi_started", n_spi - b_spi, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("rst_mid_spi");
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chki("rst_mid_spi_no_reply", tx_q.size() - b_tx, 0);
    run_vec(vt[0], "post_rst");

    // Silence after A5,F8.
    b_spi = n_spi; b_err = n_err; b_tx = tx_q.size();
    spi_resp = 8'h4B;
    send_byte(8'hA5); send_byte(8'hF8);
    repeat (TMO + 40) @(negedge clk);
`ifdef UART_CMD_TIMEOUT_EN
    chki("timeout_err", n_err - b_err, 1);
    chk1("timeout_idle", busy, 1'b0);
    chki("timeout_no_tx", tx_q.size() - b_tx, 0);
    chki("timeout_no_spi", n_spi - b_spi, 0);
`else
    chki("no_timeout_err", n_err - b_err, 0);
    chk1("no_timeout_still_busy", busy, 1'b1);
    send_byte(8'h00); send_byte(8'h5D);
    wait_idle("late_tail");
    chki("late_tail_spi", n_spi - b_spi, 1);
    chki("late_tail_tx_count", tx_q.size() - b_tx, 2);
    if (tx_q.size() >= b_tx + 2) begin
      chk8("late_tail_status", tx_q[b_tx], ACKB);
      chk8("late_tail_data", tx_q[b_tx+1], 8'h4B);
    end
`endif

    // uart_tx held active on reply entry; rx bytes during the reply are dropped.
    b_spi = n_spi; b_err = n_err; b_tx = tx_q.size();
    spi_lat = 1;
    spi_resp = 8'hC3;
    tx_force = 1'b1;
    send_byte(8'hA5); send_byte(8'hF8); send_byte(8'h00); send_byte(8'h5D);
    repeat (30) @(negedge clk);
    chki("hold_tx_withheld", tx_q.size() - b_tx, 0);
    chk1("hold_busy", busy, 1'b1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'hA6);
    tx_force = 1'b0;
    wait_idle("hold");
    chki("hold_spi_count", n_spi - b_spi, 1);
    chki("hold_tx_count", tx_q.size() - b_tx, 2);
    if (tx_q.size() >= b_tx + 2) begin
      chk8("hold_status", tx_q[b_tx], ACKB);
      chk8("hold_data", tx_q[b_tx+1], 8'hC3);
    end
    chki("hold_err", n_err - b_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
